// File: rtl/fixp_acc_pkg.sv
// Shared constants, helpers and the pipeline stage record for the fixed-point
// accumulator path.
package fixp_acc_pkg;

  // Ceiling log2 usable in constant expressions (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int FIXP_WIDTH_DEF  = 192;
  localparam int CHECK_WIDTH_DEF = 16;
  localparam int TUSER_WIDTH_DEF = 8;
  localparam int POS_W           = clog2(FIXP_WIDTH_DEF);

  // One pipeline stage worth of state for the default configuration.
  typedef struct packed {
    logic [FIXP_WIDTH_DEF-1:0]  data;
    logic [POS_W-1:0]           pos;
    logic                       find;
    logic [TUSER_WIDTH_DEF-1:0] tuser;
    logic                       tlast;
    logic                       valid;
  } stage_t;

endpackage

// File: rtl/seg_lead_one_det.sv
// Combinational leading-one detector for one scan segment; lz counts from the
// segment MSB and is only meaningful when nz is set.
module seg_lead_one_det
  import fixp_acc_pkg::*;
#(
  parameter int CHECK_WIDTH = 16
) (
  input  logic [CHECK_WIDTH-1:0]        seg,
  output logic [clog2(CHECK_WIDTH)-1:0] lz,
  output logic                          nz
);

  localparam int LZ_W = clog2(CHECK_WIDTH);

  // Walk upward from the LSB so the highest set bit is the last one to win.
  always_comb begin
    nz = |seg;
    lz = '0;
    for (int i = 0; i < CHECK_WIDTH; i++) begin
      if (seg[i]) lz = LZ_W'(CHECK_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fixp_lead_normalizer.sv
// Pipelined leading-bit detector and left normaliser. One capture stage, one
// scan stage per CHECK_WIDTH segment (MSB segment first) and a final shift
// stage. A single global enable stalls every stage together.
module fixp_lead_normalizer
  import fixp_acc_pkg::*;
#(
  parameter int FIXP_WIDTH  = FIXP_WIDTH_DEF,
  parameter int CHECK_WIDTH = CHECK_WIDTH_DEF,
  parameter int SIGNED_MODE = 0,
  parameter int TUSER_WIDTH = TUSER_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  input  logic [FIXP_WIDTH-1:0]         in_tdata,
  input  logic [TUSER_WIDTH-1:0]        in_tuser,
  input  logic                          in_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [FIXP_WIDTH-1:0]         out_data,
  output logic [FIXP_WIDTH-1:0]         out_norm,
  output logic [clog2(FIXP_WIDTH)-1:0]  out_shift,
  output logic                          out_find,
  output logic                          out_zero,
  output logic [TUSER_WIDTH-1:0]        out_tuser,
  output logic                          out_tlast
);

  localparam int NSEG = FIXP_WIDTH / CHECK_WIDTH;
  localparam int PW   = clog2(FIXP_WIDTH);
  localparam int LZW  = clog2(CHECK_WIDTH);

  typedef struct packed {
    logic [FIXP_WIDTH-1:0]  data;
    logic [PW-1:0]          pos;
    logic                   find;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic                   valid;
  } rec_t;

  // In signed mode the sign bit is folded into the rest so the first 1 marks
  // the first bit that differs from the sign; the sign position itself is 0.
  function automatic logic [FIXP_WIDTH-1:0] scan_vec(input logic [FIXP_WIDTH-1:0] d);
    if (SIGNED_MODE != 0) return {1'b0, d[FIXP_WIDTH-2:0] ^ {(FIXP_WIDTH-1){d[FIXP_WIDTH-1]}}};
    else                  return d;
  endfunction

  rec_t          stg [0:NSEG];
  logic          en;
  logic [PW-1:0] shift_c;

  assign en        = out_tready | ~out_tvalid;
  assign in_tready = en;

  // ---- capture stage (p0) ----
  // Register the incoming beat; only the valid bit is cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg[0].valid <= 1'b0;
    end else if (en) begin
      stg[0].valid <= in_tvalid;
      stg[0].data  <= in_tdata;
      stg[0].pos   <= '0;
      stg[0].find  <= 1'b0;
      stg[0].tuser <= in_tuser;
      stg[0].tlast <= in_tlast;
    end
  end

  // ---- scan stages (p1..pNSEG) ----
  for (genvar k = 1; k <= NSEG; k++) begin : g_scan
    logic [FIXP_WIDTH-1:0]  v;
    logic [CHECK_WIDTH-1:0] seg;
    logic [LZW-1:0]         lz;
    logic                   nz;

    assign v   = scan_vec(stg[k-1].data);
    assign seg = v[FIXP_WIDTH-1-(k-1)*CHECK_WIDTH -: CHECK_WIDTH];

    seg_lead_one_det #(.CHECK_WIDTH(CHECK_WIDTH)) u_det (
      .seg (seg),
      .lz  (lz),
      .nz  (nz)
    );

    // Carry the record forward; the first non-zero segment fixes pos.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stg[k].valid <= 1'b0;
      end else if (en) begin
        stg[k] <= stg[k-1];
        if (!stg[k-1].find && nz) begin
          stg[k].pos  <= PW'((k - 1) * CHECK_WIDTH) + PW'(lz);
          stg[k].find <= 1'b1;
        end
      end
    end
  end

  // ---- shift stage (output) ----
  // Signed mode keeps one sign bit above the significant bits, hence pos-1.
  always_comb begin
    shift_c = '0;
    if (stg[NSEG].find) shift_c = (SIGNED_MODE != 0) ? stg[NSEG].pos - PW'(1) : stg[NSEG].pos;
  end

  // Output registers are fully cleared so the interface reads zero in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_tvalid <= 1'b0;
      out_data   <= '0;
      out_norm   <= '0;
      out_shift  <= '0;
      out_find   <= 1'b0;
      out_zero   <= 1'b0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
    end else if (en) begin
      out_tvalid <= stg[NSEG].valid;
      out_data   <= stg[NSEG].data;
      out_norm   <= stg[NSEG].data << shift_c;
      out_shift  <= shift_c;
      out_find   <= stg[NSEG].find;
      out_zero   <= ~stg[NSEG].find;
      out_tuser  <= stg[NSEG].tuser;
      out_tlast  <= stg[NSEG].tlast;
    end
  end

endmodule

// File: tb/tb_fixp_lead_normalizer.sv
// Bench for fixp_lead_normalizer: one unsigned and one signed instance, directed
// and random beats checked against a bit-walking reference model.
module tb_fixp_lead_normalizer;

  localparam int W   = 192;
  localparam int TW  = 8;
  localparam int PW  = 8;
  localparam int LAT = 14;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // unsigned instance signals
  logic          u_in_tvalid = 1'b0, u_in_tready, u_in_tlast = 1'b0;
  logic [W-1:0]  u_in_tdata = '0;
  logic [TW-1:0] u_in_tuser = '0;
  logic          u_out_tvalid, u_out_tready = 1'b1, u_out_find, u_out_zero, u_out_tlast;
  logic [W-1:0]  u_out_data, u_out_norm;
  logic [PW-1:0] u_out_shift;
  logic [TW-1:0] u_out_tuser;

  // signed instance signals
  logic          s_in_tvalid = 1'b0, s_in_tready, s_in_tlast = 1'b0;
  logic [W-1:0]  s_in_tdata = '0;
  logic [TW-1:0] s_in_tuser = '0;
  logic          s_out_tvalid, s_out_tready = 1'b1, s_out_find, s_out_zero, s_out_tlast;
  logic [W-1:0]  s_out_data, s_out_norm;
  logic [PW-1:0] s_out_shift;
  logic [TW-1:0] s_out_tuser;

  int n_checks = 0;
  int n_fail   = 0;

  fixp_lead_normalizer #(.FIXP_WIDTH(W), .CHECK_WIDTH(16), .SIGNED_MODE(0), .TUSER_WIDTH(TW)) u_dut (
    .clk(clk), .rstn(rstn),
    .in_tvalid(u_in_tvalid), .in_tready(u_in_tready), .in_tdata(u_in_tdata),
    .in_tuser(u_in_tuser), .in_tlast(u_in_tlast),
    .out_tvalid(u_out_tvalid), .out_tready(u_out_tready), .out_data(u_out_data),
    .out_norm(u_out_norm), .out_shift(u_out_shift), .out_find(u_out_find),
    .out_zero(u_out_zero), .out_tuser(u_out_tuser), .out_tlast(u_out_tlast)
  );

  fixp_lead_normalizer #(.FIXP_WIDTH(W), .CHECK_WIDTH(16), .SIGNED_MODE(1), .TUSER_WIDTH(TW)) s_dut (
    .clk(clk), .rstn(rstn),
    .in_tvalid(s_in_tvalid), .in_tready(s_in_tready), .in_tdata(s_in_tdata),
    .in_tuser(s_in_tuser), .in_tlast(s_in_tlast),
    .out_tvalid(s_out_tvalid), .out_tready(s_out_tready), .out_data(s_out_data),
    .out_norm(s_out_norm), .out_shift(s_out_shift), .out_find(s_out_find),
    .out_zero(s_out_zero), .out_tuser(s_out_tuser), .out_tlast(s_out_tlast)
  );

  typedef struct {
    logic [W-1:0] norm;
    int           shift;
    bit           find;
  } exp_t;

  typedef struct {
    logic          vld;
    logic [W-1:0]  data;
    logic [W-1:0]  norm;
    logic [PW-1:0] shift;
    logic          find;
    logic          zero;
    logic [TW-1:0] tuser;
    logic          tlast;
  } obs_t;

  // Reference: walk from the MSB down to the first significant bit.
  function automatic exp_t ref_model(input logic [W-1:0] d, input bit sgn);
    exp_t r;
    logic [W-1:0] v;
    v = d;
    if (sgn) begin
      v = d ^ {W{d[W-1]}};
      v[W-1] = 1'b0;
    end
    r.find  = 1'b0;
    r.shift = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.find  = 1'b1;
        r.shift = (W - 1 - i) - (sgn ? 1 : 0);
        break;
      end
    end
    r.norm = d << r.shift;
    return r;
  endfunction

  function automatic obs_t sample(input bit sgn);
    obs_t o;
    if (sgn) begin
      o.vld = s_out_tvalid; o.data = s_out_data; o.norm = s_out_norm; o.shift = s_out_shift;
      o.find = s_out_find; o.zero = s_out_zero; o.tuser = s_out_tuser; o.tlast = s_out_tlast;
    end else begin
      o.vld = u_out_tvalid; o.data = u_out_data; o.norm = u_out_norm; o.shift = u_out_shift;
      o.find = u_out_find; o.zero = u_out_zero; o.tuser = u_out_tuser; o.tlast = u_out_tlast;
    end
    return o;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    obs_t o;
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      n_checks++;
      if (o.vld !== 1'b0 || o.find !== 1'b0 || o.zero !== 1'b0 || o.shift !== '0) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: vld=%b find=%b zero=%b shift=%0d, required all 0", s, o.vld, o.find, o.zero, o.shift);
      end
      n_checks++;
      if (o.data !== '0 || o.norm !== '0 || o.tuser !== '0 || o.tlast !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: data=%h norm=%h tuser=%h tlast=%b, required all 0", s, o.data, o.norm, o.tuser, o.tlast);
      end
    end
  endtask

  // One beat into an empty pipeline; checks latency, result and single emission.
  task automatic test_single_beat(input bit sgn, input logic [W-1:0] d, input logic [TW-1:0] tu);
    exp_t e;
    obs_t o;
    int   n;
    e = ref_model(d, sgn);
    @(negedge clk);
    if (sgn) begin
      s_out_tready = 1'b1; s_in_tvalid = 1'b1; s_in_tdata = d; s_in_tuser = tu; s_in_tlast = 1'b1;
    end else begin
      u_out_tready = 1'b1; u_in_tvalid = 1'b1; u_in_tdata = d; u_in_tuser = tu; u_in_tlast = 1'b1;
    end
    #1;
    n_checks++;
    if ((sgn ? s_in_tready : u_in_tready) !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready dut%0d: in_tready=0, required 1", sgn);
    end
    @(posedge clk);
    @(negedge clk);
    s_in_tvalid = 1'b0; u_in_tvalid = 1'b0;
    n = 1;
    o = sample(sgn);
    while (o.vld !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
      o = sample(sgn);
    end
    n_checks++;
    if (o.vld !== 1'b1 || n != LAT) begin
      n_fail++;
      $display("FAIL single_latency dut%0d: got %0d cycles (vld=%b), required %0d", sgn, n, o.vld, LAT);
    end
    n_checks++;
    if (o.data !== d || o.norm !== e.norm) begin
      n_fail++;
      $display("FAIL single_data dut%0d: data=%h norm=%h, required data=%h norm=%h", sgn, o.data, o.norm, d, e.norm);
    end
    n_checks++;
    if (o.shift !== PW'(e.shift) || o.find !== e.find || o.zero !== !e.find) begin
      n_fail++;
      $display("FAIL single_shift dut%0d: shift=%0d find=%b zero=%b, required shift=%0d find=%b zero=%b",
               sgn, o.shift, o.find, o.zero, e.shift, e.find, !e.find);
    end
    n_checks++;
    if (o.tuser !== tu || o.tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL single_side dut%0d: tuser=%h tlast=%b, required tuser=%h tlast=1", sgn, o.tuser, o.tlast, tu);
    end
    @(posedge clk); @(negedge clk);
    o = sample(sgn);
    n_checks++;
    if (o.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_once dut%0d: out_tvalid=%b after consumption, required 0", sgn, o.vld);
    end
  endtask

  task automatic test_unsigned_directed();
    logic [W-1:0] d;
    d = '0; d[W-1] = 1'b1; test_single_beat(1'b0, d, 8'h11);
    d = '0; d[0] = 1'b1;   test_single_beat(1'b0, d, 8'h22);
    d = '0; d[16] = 1'b1;  test_single_beat(1'b0, d, 8'h33);
    d = '0;                test_single_beat(1'b0, d, 8'h44);
  endtask

  task automatic test_signed_directed();
    logic [W-1:0] d;
    d = '1; d[3:0] = 4'h0; test_single_beat(1'b1, d, 8'h55);
    d = '1;                test_single_beat(1'b1, d, 8'h66);
    d = '0; d[0] = 1'b1;   test_single_beat(1'b1, d, 8'h77);
    d = '0;                test_single_beat(1'b1, d, 8'h88);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = rand_word() >> $urandom_range(0, W - 1);
      test_single_beat(i[0], d, TW'(i));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] din [20];
    exp_t e;
    obs_t cur, prev;
    bit   stalled;
    int   sent, got, cyc, extra;
    for (int i = 0; i < 20; i++) din[i] = rand_word() >> $urandom_range(0, W - 1);
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    prev = sample(1'b0);
    while (got < 20 && cyc < 600) begin
      @(negedge clk);
      u_out_tready = ($urandom_range(0, 9) < 6);
      if (sent < 20) begin
        u_in_tvalid = 1'b1; u_in_tdata = din[sent]; u_in_tuser = TW'(sent);
        u_in_tlast = (sent == 9 || sent == 19);
      end else begin
        u_in_tvalid = 1'b0;
      end
      #1;
      cur = sample(1'b0);
      if (stalled) begin
        n_checks++;
        if (cur.vld !== 1'b1 || cur.data !== prev.data || cur.norm !== prev.norm ||
            cur.shift !== prev.shift || cur.tuser !== prev.tuser || cur.tlast !== prev.tlast) begin
          n_fail++;
          $display("FAIL b2b_stall: vld=%b tuser=%h shift=%0d changed, required held at tuser=%h shift=%0d",
                   cur.vld, cur.tuser, cur.shift, prev.tuser, prev.shift);
        end
      end
      if (u_in_tvalid && u_in_tready) sent++;
      if (cur.vld === 1'b1 && u_out_tready) begin
        e = ref_model(din[got], 1'b0);
        n_checks++;
        if (cur.tuser !== TW'(got) || cur.data !== din[got] || cur.tlast !== (got == 9 || got == 19)) begin
          n_fail++;
          $display("FAIL b2b_order: tuser=%0d tlast=%b data=%h, required tuser=%0d tlast=%b data=%h",
                   cur.tuser, cur.tlast, cur.data, got, (got == 9 || got == 19), din[got]);
        end
        n_checks++;
        if (cur.shift !== PW'(e.shift) || cur.norm !== e.norm) begin
          n_fail++;
          $display("FAIL b2b_result idx %0d: shift=%0d norm=%h, required shift=%0d norm=%h",
                   got, cur.shift, cur.norm, e.shift, e.norm);
        end
        got++;
      end
      stalled = (cur.vld === 1'b1) && !u_out_tready;
      prev = cur;
      cyc++;
    end
    @(negedge clk);
    u_in_tvalid = 1'b0; u_out_tready = 1'b1;
    n_checks++;
    if (got != 20) begin
      n_fail++;
      $display("FAIL b2b_count: received %0d beats within budget, required 20", got);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_out_tvalid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_dup: %0d extra beats emitted, required 0", extra);
    end
  endtask

  task automatic test_reset_flush();
    int n, seen;
    @(negedge clk);
    u_out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      u_in_tvalid = 1'b1; u_in_tdata = rand_word(); u_in_tuser = TW'(8'hA0 + i); u_in_tlast = 1'b0;
      @(negedge clk);
    end
    u_in_tvalid = 1'b0;
    n = 0;
    while (u_out_tvalid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (u_out_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_fill: out_tvalid=%b before reset, required 1", u_out_tvalid);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (u_out_tvalid !== 1'b0 || u_out_data !== '0 || u_out_find !== 1'b0 || u_out_norm !== '0) begin
      n_fail++;
      $display("FAIL flush_async: vld=%b find=%b data=%h, required all 0 immediately", u_out_tvalid, u_out_find, u_out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    u_out_tready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (u_out_tvalid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_stale: %0d stale beats emitted after reset, required 0", seen);
    end
    test_single_beat(1'b0, rand_word() >> 40, 8'hC3);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    test_unsigned_directed();
    test_signed_directed();
    test_random();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
